tdm_demux4: RTL and testbench
=============================

# tdm_demux4

Four-lane time-division demultiplexer: the receive-side counterpart of the 4-to-1 word multiplexer. It accepts a stream of WIDTH-bit words, one word per time slot, with the first slot marked by a start-of-frame flag. It steers each word into one of four lane registers by slot position. When a frame is complete it presents all four lanes at once with a one-cycle valid pulse. It sits after the multiplexed link and restores the parallel a/b/c/d words that fed the multiplexer.

## Interface

Parameters:
- WIDTH, 5: width of every data word and lane.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_data/in_sof are valid this cycle; one word is consumed per valid cycle. There is no backpressure.
- in_sof  input  1  start of frame; qualifies in_data as slot 0 (lane a).
- in_data  input  WIDTH  slot word.
- err_clr  input  1  synchronous clear of frame_err.
- out_a, out_b, out_c, out_d  output  WIDTH  lane words for slots 0..3.
- out_valid  output  1  one-cycle pulse when out_a..out_d update.
- frame_err  output  1  sticky flag for a truncated frame.

## Operation

- State machine with two states: HUNT and COLLECT. There is a 2-bit slot counter and four WIDTH-bit shadow registers.
- Reset state (asynchronous, rst_n low):
  - State is HUNT and slot is 0.
  - All shadow registers are 0.
  - out_a..out_d are 0.
  - out_valid is 0 and frame_err is 0.
- HUNT:
  - in_valid=1 and in_sof=1: shadow0 ← in_data; slot ← 1; go to COLLECT.
  - in_valid=1 and in_sof=0: the word is discarded with no flag; stay in HUNT.
- COLLECT, with in_valid=1 and in_sof=0:
  - shadow[slot] ← in_data; slot increments.
  - If slot was 3: out_a..out_d ← shadow0, shadow1, shadow2, in_data (the slot-3 word is bypassed directly, not taken from the shadow). out_valid pulses. Slot ← 0 and state returns to HUNT.
- COLLECT, with in_valid=1 and in_sof=1 (early SOF, partial frame):
  - frame_err ← 1.
  - The partial frame is abandoned; out_a..out_d and out_valid are untouched.
  - shadow0 ← in_data; slot ← 1; stay in COLLECT, so the new frame starts immediately.
- in_valid=0: no state change, in either state. Gaps between slots are allowed and unbounded.
- out_a..out_d hold their last published frame until the next complete frame. Partial frames never reach the outputs.
- frame_err:
  - Set by an early SOF only.
  - Cleared by err_clr=1.
  - If set and clear occur in the same cycle, set wins.
- The slot counter wraps 3→0 only through frame completion; it never free-runs.

## Timing

- All outputs are registered. There is no combinational path from inputs to outputs.
- Latency: the slot-3 word is sampled at edge k. out_a..out_d and out_valid=1 are visible after edge k. out_valid returns to 0 after edge k+1 unless another frame completes at k+1.
- Minimum frame length is 4 consecutive valid cycles. Back-to-back frames are supported: an SOF word at edge k+1 is accepted, with no dead cycle.
- Throughput is one word per cycle.
- frame_err rises after the edge that samples the early SOF.
- Reset mid-frame: all state clears immediately and asynchronously. The first word after reset release must carry SOF to be accepted.

## Test plan

- **Reset values.** Assert rst_n=0 mid-stream. Required: all outputs are 0 immediately, without waiting for a clock edge. After release, feed the words 3, 4, 5, 6 with no SOF. Required: no out_valid, and the outputs stay 0.
- **Basic frame.** Feed valid words 4 (SOF), 5, 6, 7 on consecutive cycles. Required: one cycle after the 7 is sampled, out_a=4, out_b=5, out_c=6, out_d=7 and out_valid=1 for exactly one cycle.
- **Gapped frame followed by a back-to-back frame.**
  - Feed 1 (SOF), then idle for 2 cycles, then 2, 3, idle, 4. Required: outputs become 1, 2, 3, 4 with a single pulse.
  - Immediately follow with 8 (SOF), 9, 10, 11 and no gap. Required: a second pulse, with outputs 8, 9, 10, 11.
- **Early SOF.** Feed 4 (SOF), 5, then 12 (SOF), 13, 14, 15. Required: frame_err=1 after the 12 is sampled, with no pulse for the aborted frame. The next pulse shows 12, 13, 14, 15, and frame_err stays 1.
- **Error clear.**
  - Assert err_clr alone. Required: frame_err=0 next cycle.
  - Assert err_clr in the same cycle as an early SOF. Required: frame_err stays 1.
- **Width limit.** Feed 31, 0, 31, 0 (SOF on the first word) with WIDTH=5. Required: out_a=31, out_b=0, out_c=31, out_d=0, with no truncation.

Source files
------------

// File: rtl/tdm_demux4_if.sv
// tdm_demux4_if
//   Bundles the slot-stream input side and the parallel lane output side of
//   the four-lane TDM demultiplexer.
//   Signals:
//     in_valid  - in_sof/in_data valid this cycle (no backpressure)
//     in_sof    - start of frame, marks slot 0 (lane a)
//     in_data   - slot word, WIDTH bits
//     err_clr   - synchronous clear of frame_err
//     out_a..d  - lane words for slots 0..3
//     out_valid - one-cycle pulse when out_a..out_d update
//     frame_err - sticky truncated-frame flag
//   Modports:
//     master - the stream source / lane consumer (testbench side)
//     slave  - the demultiplexer itself
interface tdm_demux4_if #(
    parameter int WIDTH = 5
);
    logic             in_valid;
    logic             in_sof;
    logic [WIDTH-1:0] in_data;
    logic             err_clr;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [WIDTH-1:0] out_c;
    logic [WIDTH-1:0] out_d;
    logic             out_valid;
    logic             frame_err;

    modport master (
        output in_valid, in_sof, in_data, err_clr,
        input  out_a, out_b, out_c, out_d, out_valid, frame_err
    );

    modport slave (
        input  in_valid, in_sof, in_data, err_clr,
        output out_a, out_b, out_c, out_d, out_valid, frame_err
    );
endinterface

// File: rtl/tdm_demux4.sv
// tdm_demux4
//   Four-lane time-division demultiplexer. Words arrive one per valid cycle;
//   the SOF-flagged word is slot 0. Slots 0..2 are held in shadow registers
//   and, when slot 3 arrives, all four lanes are published together with a
//   one-cycle out_valid pulse. An SOF inside a frame abandons the partial
//   frame, sets the sticky frame_err flag and restarts collection at once.
//   Ports:
//     clk   - rising-edge clock
//     rst_n - asynchronous active-low reset
//     bus   - tdm_demux4_if.slave (stream in, lanes/valid/error out)
module tdm_demux4 #(
    parameter int WIDTH = 5
) (
    input logic          clk,
    input logic          rst_n,
    tdm_demux4_if.slave  bus
);

    localparam logic [0:0] ST_HUNT    = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;

    logic [0:0]       r_state;
    logic [1:0]       r_slot;
    logic [WIDTH-1:0] r_shadow0;
    logic [WIDTH-1:0] r_shadow1;
    logic [WIDTH-1:0] r_shadow2;
    logic [WIDTH-1:0] r_out_a;
    logic [WIDTH-1:0] r_out_b;
    logic [WIDTH-1:0] r_out_c;
    logic [WIDTH-1:0] r_out_d;
    logic             r_out_valid;
    logic             r_frame_err;

    logic w_sof_word;
    logic w_data_word;
    logic w_early_sof;

    assign w_sof_word  = bus.in_valid &  bus.in_sof;
    assign w_data_word = bus.in_valid & ~bus.in_sof;
    assign w_early_sof = w_sof_word & (r_state == ST_COLLECT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_HUNT;
            r_slot      <= 2'd0;
            r_shadow0   <= '0;
            r_shadow1   <= '0;
            r_shadow2   <= '0;
            r_out_a     <= '0;
            r_out_b     <= '0;
            r_out_c     <= '0;
            r_out_d     <= '0;
            r_out_valid <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;

            if (w_sof_word) begin
                // SOF always (re)starts a frame, whether hunting or mid-frame.
                r_shadow0 <= bus.in_data;
                r_slot    <= 2'd1;
                r_state   <= ST_COLLECT;
            end else if (w_data_word && (r_state == ST_COLLECT)) begin
                case (r_slot)
                    2'd1: r_shadow1 <= bus.in_data;
                    2'd2: r_shadow2 <= bus.in_data;
                    2'd3: begin
                        // Slot-3 word goes straight to lane d; no shadow needed.
                        r_out_a     <= r_shadow0;
                        r_out_b     <= r_shadow1;
                        r_out_c     <= r_shadow2;
                        r_out_d     <= bus.in_data;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_HUNT;
                    end
                    default: r_shadow0 <= bus.in_data; // slot 0 never seen while collecting
                endcase
                // Natural 2-bit wrap takes slot 3 back to 0 on completion.
                r_slot <= r_slot + 2'd1;
            end

            // Set has priority over a simultaneous clear.
            if (w_early_sof) begin
                r_frame_err <= 1'b1;
            end else if (bus.err_clr) begin
                r_frame_err <= 1'b0;
            end
        end
    end

    assign bus.out_a     = r_out_a;
    assign bus.out_b     = r_out_b;
    assign bus.out_c     = r_out_c;
    assign bus.out_d     = r_out_d;
    assign bus.out_valid = r_out_valid;
    assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4
//   Directed and randomized stimulus for tdm_demux4 with a frame-queue
//   reference model.
module tb_tdm_demux4;

    localparam int WIDTH = 5;

    logic clk;
    logic rst_n;

    tdm_demux4_if #(.WIDTH(WIDTH)) bus ();

    tdm_demux4 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model: words of the frame in progress, plus expected outputs.
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_a, exp_b, exp_c, exp_d;
    logic             exp_v, exp_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".a"},   32'(bus.out_a),     32'(exp_a));
        chk({tag, ".b"},   32'(bus.out_b),     32'(exp_b));
        chk({tag, ".c"},   32'(bus.out_c),     32'(exp_c));
        chk({tag, ".d"},   32'(bus.out_d),     32'(exp_d));
        chk({tag, ".vld"}, 32'(bus.out_valid), 32'(exp_v));
        chk({tag, ".err"}, 32'(bus.frame_err), 32'(exp_err));
    endtask

    task automatic model_reset();
        q.delete();
        exp_a = '0; exp_b = '0; exp_c = '0; exp_d = '0;
        exp_v = 1'b0; exp_err = 1'b0;
    endtask

    // A frame is SOF plus three further words; an SOF while a frame is open
    // is an error and restarts the frame. Words outside any frame are dropped.
    task automatic model_step(input logic v, input logic s, input logic [WIDTH-1:0] d, input logic c);
        exp_v = 1'b0;
        if (c) exp_err = 1'b0;
        if (v) begin
            if (s) begin
                if (q.size() != 0) exp_err = 1'b1;
                q.delete();
                q.push_back(d);
            end else if (q.size() != 0) begin
                q.push_back(d);
                if (q.size() == 4) begin
                    exp_a = q[0]; exp_b = q[1]; exp_c = q[2]; exp_d = q[3];
                    exp_v = 1'b1;
                    q.delete();
                end
            end
        end
    endtask

    // Drive one cycle of inputs, advance the model, check after the edge.
    task automatic step(input string tag, input logic v, input logic s,
                        input logic [WIDTH-1:0] d, input logic c);
        bus.in_valid = v;
        bus.in_sof   = s;
        bus.in_data  = d;
        bus.err_clr  = c;
        model_step(v, s, d, c);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        // Power-on reset, checked before the first clock edge.
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = '0;
        bus.err_clr  = 1'b0;
        model_reset();
        #3;
        check_all("por");
        #19;
        rst_n = 1'b1;

        // Basic frame 4,5,6,7.
        step("basic0", 1'b1, 1'b1, 5'd4, 1'b0);
        step("basic1", 1'b1, 1'b0, 5'd5, 1'b0);
        step("basic2", 1'b1, 1'b0, 5'd6, 1'b0);
        step("basic3", 1'b1, 1'b0, 5'd7, 1'b0);
        chk("basic.out_a", 32'(bus.out_a), 32'd4);
        chk("basic.out_d", 32'(bus.out_d), 32'd7);
        chk("basic.pulse", 32'(bus.out_valid), 32'd1);
        idle("basic_after");
        chk("basic.pulse_end", 32'(bus.out_valid), 32'd0);

        // Gapped frame 1,_,_,2,3,_,4 then back-to-back 8,9,10,11.
        step("gap0", 1'b1, 1'b1, 5'd1, 1'b0);
        idle("gap_i0");
        idle("gap_i1");
        step("gap1", 1'b1, 1'b0, 5'd2, 1'b0);
        step("gap2", 1'b1, 1'b0, 5'd3, 1'b0);
        idle("gap_i2");
        step("gap3", 1'b1, 1'b0, 5'd4, 1'b0);
        chk("gap.out_c", 32'(bus.out_c), 32'd3);
        step("b2b0", 1'b1, 1'b1, 5'd8, 1'b0);
        chk("b2b.pulse_end", 32'(bus.out_valid), 32'd0);
        step("b2b1", 1'b1, 1'b0, 5'd9, 1'b0);
        step("b2b2", 1'b1, 1'b0, 5'd10, 1'b0);
        step("b2b3", 1'b1, 1'b0, 5'd11, 1'b0);
        chk("b2b.out_b", 32'(bus.out_b), 32'd9);
        chk("b2b.pulse", 32'(bus.out_valid), 32'd1);

        // Early SOF: 4,5 abandoned by 12.
        step("early0", 1'b1, 1'b1, 5'd4, 1'b0);
        step("early1", 1'b1, 1'b0, 5'd5, 1'b0);
        step("early2", 1'b1, 1'b1, 5'd12, 1'b0);
        chk("early.err_set", 32'(bus.frame_err), 32'd1);
        step("early3", 1'b1, 1'b0, 5'd13, 1'b0);
        step("early4", 1'b1, 1'b0, 5'd14, 1'b0);
        step("early5", 1'b1, 1'b0, 5'd15, 1'b0);
        chk("early.out_a", 32'(bus.out_a), 32'd12);
        chk("early.err_held", 32'(bus.frame_err), 32'd1);

        // Error clear alone, then clear colliding with an early SOF.
        step("clr0", 1'b0, 1'b0, 5'd0, 1'b1);
        chk("clr.alone", 32'(bus.frame_err), 32'd0);
        step("clr1", 1'b1, 1'b1, 5'd4, 1'b0);
        step("clr2", 1'b1, 1'b0, 5'd5, 1'b0);
        step("clr3", 1'b1, 1'b1, 5'd20, 1'b1);
        chk("clr.set_wins", 32'(bus.frame_err), 32'd1);
        step("clr4", 1'b1, 1'b0, 5'd21, 1'b0);
        step("clr5", 1'b1, 1'b0, 5'd22, 1'b0);
        step("clr6", 1'b1, 1'b0, 5'd23, 1'b0);

        // Width limit.
        step("wid0", 1'b1, 1'b1, 5'd31, 1'b0);
        step("wid1", 1'b1, 1'b0, 5'd0, 1'b0);
        step("wid2", 1'b1, 1'b0, 5'd31, 1'b0);
        step("wid3", 1'b1, 1'b0, 5'd0, 1'b0);
        chk("wid.out_a", 32'(bus.out_a), 32'd31);
        chk("wid.out_c", 32'(bus.out_c), 32'd31);

        // Reset mid-stream with outputs and error flag non-zero.
        step("mid0", 1'b1, 1'b1, 5'd1, 1'b0);
        step("mid1", 1'b1, 1'b0, 5'd2, 1'b0);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step("nosof0", 1'b1, 1'b0, 5'd3, 1'b0);
        step("nosof1", 1'b1, 1'b0, 5'd4, 1'b0);
        step("nosof2", 1'b1, 1'b0, 5'd5, 1'b0);
        step("nosof3", 1'b1, 1'b0, 5'd6, 1'b0);
        chk("nosof.out_d", 32'(bus.out_d), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            step("rand",
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 4) == 0,
                 WIDTH'($urandom),
                 $urandom_range(0, 15) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
